tmr_recovery_ctrl: RTL
======================

Name: tmr_recovery_ctrl

Overview:
- Sequencing controller for the TMR RISC-V voter.
- Consumes the voter's per-cycle pairwise agreement vector, identifies the faulty core, stalls all three cores, and runs a resync handshake that reloads the faulty core's architectural state from a healthy donor.
- Keeps saturating per-core fault counters, retires a core that exceeds a threshold, and raises fatal when no majority exists.

Parameters:
- CNT_W, 8, width of per-core fault counters.
- RETIRE_THRESH, 4, fault count at which a core is marked disabled.
- RESYNC_TIMEOUT, 64, max cycles in RESYNC awaiting resync_ack before declaring fatal.
- STALL_CYCLES, 2, pipeline drain cycles between stall assertion and resync_req.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- agree_vec  in  3  {A==B, B==C, A==C}, AND-reduced over all voted signals
- cmp_valid  in  1  agree_vec is meaningful this cycle
- resync_ack  in  1  one-cycle pulse: state copy into target core complete
- clr_fatal  in  1  software clear of FATAL; returns to MONITOR
- stall  out  1  freeze all three cores
- resync_req  out  1  level request; held until ack or timeout
- resync_src  out  2  donor core index (0=A, 1=B, 2=C)
- resync_dst  out  3  one-hot target core {C,B,A}
- fault_cnt_a/b/c  out  CNT_W each  saturating fault counters
- core_disabled  out  3  one-hot retired cores {C,B,A}
- fatal  out  1  unrecoverable divergence
- ctrl_state  out  3  FSM state encoding for debug

Behaviour:
- Reset, synchronous on clk with rst=1: all outputs 0, FSM = MONITOR, counters 0, timers 0. Reset mid-RESYNC drops resync_req the same edge.
- Decode, when cmp_valid=1 and no core is disabled:
  - 111: healthy.
  - 100: C faulty.
  - 010: A faulty.
  - 001: B faulty.
  - 000, 110, 101 or 011: no majority or inconsistent → FATAL.
- Donor is the lowest-index healthy core.
- Degraded mode, exactly one core disabled: only the pair bit of the two live cores is checked. 1 = healthy; 0 = FATAL, since the faulty core cannot be located.
- Two or more cores disabled → FATAL.
- FSM states, encoded 0-4:
  - MONITOR: stall=0. On a single-core fault, latch dst/src, increment that core's counter (saturate at 2^CNT_W-1), go to DRAIN.
  - DRAIN: stall=1 for STALL_CYCLES cycles, then RESYNC.
  - RESYNC: stall=1, resync_req=1, timer counts. On resync_ack go to RECHECK. If the timer reaches RESYNC_TIMEOUT with no ack, go to FATAL.
  - RECHECK: stall=0 for one cycle, then MONITOR. If the counter of the dst core is ≥ RETIRE_THRESH, set its core_disabled bit this cycle.
  - FATAL: stall=1, fatal=1, absorbing. clr_fatal returns to MONITOR; counters and disabled bits are kept.
- Faults reported while not in MONITOR are ignored; agree_vec is invalid while stalled.
- resync_ack arriving outside RESYNC is ignored.
- Latency: fault sample to stall = 1 cycle (registered); stall to resync_req = STALL_CYCLES.
- resync_src/resync_dst hold stable from DRAIN entry until the RECHECK exit.

Optional Feature:
- Macro TMR_FAULT_TSTAMP_EN.
- When defined:
  - Adds a free-running 32-bit cycle counter.
  - Adds output last_fault_ts[31:0], captured on each MONITOR→DRAIN or →FATAL transition.
  - Adds output last_fault_core[1:0].
  - Both outputs reset to 0.
- When undefined: none of these ports or registers exist; all other behaviour is unchanged.

Decomposition:
- Shared package tmr_pkg:
  - FSM state encoding constants.
  - Core index constants CORE_A/B/C.
  - Agreement bit positions AB=2, BC=1, AC=0.
  - Decode function agreement→{faulty_onehot, no_majority}.
- Sub-module tmr_fault_decode (combinational): agree_vec plus core_disabled → faulty one-hot, donor index, fatal_cond. Reused by future voter-side checkers.

Test Plan:
- Reset: rst=1 for 2 cycles → all outputs 0, ctrl_state=0. Then agree_vec=111, cmp_valid=1 for 20 cycles → stall stays 0, counters stay 0.
- Single fault on C, agree_vec=100 for one cycle:
  - Next cycle stall=1, fault_cnt_c=1, resync_dst=100, resync_src=0.
  - resync_req asserts 2 cycles later.
  - ack pulse → stall drops 1 cycle after ack.
- Retirement: inject fault on A (010) four times with acks → core_disabled=001 in RECHECK, donor=B. Then B/C pair mismatch (agree_vec BC bit=0) → fatal=1.
- No majority: agree_vec=000 → FATAL within 1 cycle, stall=1. clr_fatal pulse → MONITOR, counters unchanged.
- Timeout: fault on B (001), withhold ack → after 64 RESYNC cycles, resync_req=0, fatal=1.
- Corner cases:
  - rst asserted in RESYNC → resync_req=0 next edge.
  - ack with cmp_valid=0 and agree_vec=000 in MONITOR → no state change.

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR recovery path: FSM encoding, core indices,
// agreement-bit positions and the full-TMR agreement decode.
package tmr_pkg;

    typedef enum logic [2:0] {
        ST_MONITOR = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_RESYNC  = 3'd2,
        ST_RECHECK = 3'd3,
        ST_FATAL   = 3'd4
    } ctrl_state_e;

    localparam logic [1:0] CORE_A = 2'd0;
    localparam logic [1:0] CORE_B = 2'd1;
    localparam logic [1:0] CORE_C = 2'd2;

    localparam int AB = 2;
    localparam int BC = 1;
    localparam int AC = 0;

    typedef struct packed {
        logic [2:0] faulty_onehot;
        logic       no_majority;
    } decode_t;

    // Exactly one pair agreeing points at the core outside that pair.
    function automatic decode_t decode_agree(input logic [2:0] agree);
        decode_t r;
        r.faulty_onehot = 3'b000;
        r.no_majority   = 1'b0;
        case (agree)
            3'b111:  r.faulty_onehot = 3'b000;
            3'b100:  r.faulty_onehot = 3'b100;
            3'b010:  r.faulty_onehot = 3'b001;
            3'b001:  r.faulty_onehot = 3'b010;
            default: r.no_majority   = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] onehot);
        logic [1:0] idx;
        idx = CORE_A;
        if (onehot[1]) idx = CORE_B;
        if (onehot[2]) idx = CORE_C;
        return idx;
    endfunction

endpackage

// File: rtl/tmr_fault_decode.sv
// Combinational fault locator: agreement vector plus retired-core mask
// gives the faulty core, the donor for its resync, and a fatal condition.
module tmr_fault_decode
    import tmr_pkg::*;
(
    input  logic [2:0] agree_vec,
    input  logic [2:0] core_disabled,
    output logic [2:0] faulty,
    output logic [1:0] donor,
    output logic       fatal_cond
);

    decode_t dec;

    always_comb begin
        dec        = decode_agree(agree_vec);
        faulty     = 3'b000;
        donor      = CORE_A;
        fatal_cond = 1'b0;
        case (core_disabled)
            3'b000: begin
                faulty     = dec.faulty_onehot;
                fatal_cond = dec.no_majority;
                donor      = dec.faulty_onehot[0] ? CORE_B : CORE_A;
            end
            // With one core retired a mismatch cannot be attributed to either survivor.
            3'b001: begin
                fatal_cond = ~agree_vec[BC];
                donor      = CORE_B;
            end
            3'b010: begin
                fatal_cond = ~agree_vec[AC];
                donor      = CORE_A;
            end
            3'b100: begin
                fatal_cond = ~agree_vec[AB];
                donor      = CORE_A;
            end
            default: fatal_cond = 1'b1;
        endcase
    end

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// TMR recovery sequencer: stall, drain, resync the faulty core from a donor,
// count faults and retire repeat offenders. Optional TMR_FAULT_TSTAMP_EN adds fault time stamps.
module tmr_recovery_ctrl
    import tmr_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int RETIRE_THRESH  = 4,
    parameter int RESYNC_TIMEOUT = 64,
    parameter int STALL_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       agree_vec,
    input  logic             cmp_valid,
    input  logic             resync_ack,
    input  logic             clr_fatal,
    output logic             stall,
    output logic             resync_req,
    output logic [1:0]       resync_src,
    output logic [2:0]       resync_dst,
    output logic [CNT_W-1:0] fault_cnt_a,
    output logic [CNT_W-1:0] fault_cnt_b,
    output logic [CNT_W-1:0] fault_cnt_c,
    output logic [2:0]       core_disabled,
    output logic             fatal,
`ifdef TMR_FAULT_TSTAMP_EN
    output logic [31:0]      last_fault_ts,
    output logic [1:0]       last_fault_core,
`endif
    output logic [2:0]       ctrl_state
);

    localparam int TIMER_W = $clog2(RESYNC_TIMEOUT + STALL_CYCLES + 1);

    ctrl_state_e             state_q, state_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [1:0]              src_q, src_d;
    logic [2:0]              dst_q, dst_d;
    logic [2:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]              dis_q, dis_d;

    logic [2:0] faulty;
    logic [1:0] donor;
    logic       fatal_cond;
    logic       multi_dis;

    tmr_fault_decode u_decode (
        .agree_vec     (agree_vec),
        .core_disabled (dis_q),
        .faulty        (faulty),
        .donor         (donor),
        .fatal_cond    (fatal_cond)
    );

    assign multi_dis = (dis_q[0] & dis_q[1]) | (dis_q[0] & dis_q[2]) | (dis_q[1] & dis_q[2]);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        src_d      = src_q;
        dst_d      = dst_q;
        cnt_d      = cnt_q;
        dis_d      = dis_q;
        stall      = 1'b1;
        resync_req = 1'b0;
        fatal      = 1'b0;
        case (state_q)
            ST_MONITOR: begin
                stall = 1'b0;
                if (multi_dis || (cmp_valid && fatal_cond)) begin
                    state_d = ST_FATAL;
                end else if (cmp_valid && (faulty != 3'b000)) begin
                    src_d   = donor;
                    dst_d   = faulty;
                    timer_d = '0;
                    state_d = ST_DRAIN;
                    for (int i = 0; i < 3; i++) begin
                        if (faulty[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (timer_q == TIMER_W'(STALL_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = ST_RESYNC;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RESYNC: begin
                resync_req = 1'b1;
                if (resync_ack) begin
                    state_d = ST_RECHECK;
                    // Retire on entry so the disabled bit is already visible during RECHECK.
                    for (int i = 0; i < 3; i++) begin
                        if (dst_q[i] && (int'(cnt_q[i]) >= RETIRE_THRESH)) begin
                            dis_d[i] = 1'b1;
                        end
                    end
                end else if (timer_q == TIMER_W'(RESYNC_TIMEOUT - 1)) begin
                    state_d = ST_FATAL;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RECHECK: begin
                stall   = 1'b0;
                src_d   = CORE_A;
                dst_d   = 3'b000;
                state_d = ST_MONITOR;
            end
            ST_FATAL: begin
                fatal = 1'b1;
                if (clr_fatal) begin
                    src_d   = CORE_A;
                    dst_d   = 3'b000;
                    timer_d = '0;
                    state_d = ST_MONITOR;
                end
            end
            default: begin
                state_d = ST_MONITOR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_MONITOR;
            timer_q <= '0;
            src_q   <= CORE_A;
            dst_q   <= 3'b000;
            cnt_q   <= '0;
            dis_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            dis_q   <= dis_d;
        end
    end

    assign resync_src    = src_q;
    assign resync_dst    = dst_q;
    assign fault_cnt_a   = cnt_q[0];
    assign fault_cnt_b   = cnt_q[1];
    assign fault_cnt_c   = cnt_q[2];
    assign core_disabled = dis_q;
    assign ctrl_state    = state_q;

`ifdef TMR_FAULT_TSTAMP_EN
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] ts_q, ts_d;
    logic [1:0]  fcore_q, fcore_d;

    // Core index 3 marks a fatal entry that could not be tied to one core.
    always_comb begin
        cyc_d   = cyc_q + 32'd1;
        ts_d    = ts_q;
        fcore_d = fcore_q;
        if ((state_d != state_q) && ((state_d == ST_DRAIN) || (state_d == ST_FATAL))) begin
            ts_d    = cyc_q;
            fcore_d = ((state_d == ST_FATAL) && (state_q != ST_RESYNC)) ? 2'd3 : onehot_to_idx(dst_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q   <= '0;
            ts_q    <= '0;
            fcore_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            ts_q    <= ts_d;
            fcore_q <= fcore_d;
        end
    end

    assign last_fault_ts   = ts_q;
    assign last_fault_core = fcore_q;
`endif

endmodule
